// File: rtl/mmips_run_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module   : mmips_run_monitor_if
//  Purpose  : Bundles the data-memory read port and the dump stream port of
//             the mMIPS end-of-run monitor.
//  Ports    : mem_rd_en/bank/addr  monitor -> memory read request
//             mem_rd_data          memory -> monitor, 1 cycle after request
//             dump_valid/data/last monitor -> sink word stream
//             dump_ready           sink -> monitor acceptance
//  Modports : master = monitor side, slave = memory/sink side
//  Revision : 1.0 - initial release
// ============================================================================
interface mmips_run_monitor_if #(
   parameter int N_BANKS    = 64,
   parameter int BANK_DEPTH = 512,
   parameter int DATA_W     = 32
);
   localparam int BANK_W = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
   localparam int ADDR_W = $clog2(BANK_DEPTH);

   logic              mem_rd_en;
   logic [BANK_W-1:0] mem_rd_bank;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic [DATA_W-1:0] mem_rd_data;
   logic              dump_valid;
   logic              dump_ready;
   logic [DATA_W-1:0] dump_data;
   logic              dump_last;

   modport master (
      output mem_rd_en, mem_rd_bank, mem_rd_addr,
      input  mem_rd_data,
      output dump_valid, dump_data, dump_last,
      input  dump_ready
   );

   modport slave (
      input  mem_rd_en, mem_rd_bank, mem_rd_addr,
      output mem_rd_data,
      input  dump_valid, dump_data, dump_last,
      output dump_ready
   );
endinterface
`default_nettype wire

// File: rtl/mmips_run_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : mmips_run_monitor
//  Purpose  : End-of-run monitor for mMIPS. Counts enabled cycles from arm to
//             halt (HALT_PC seen) or cycle-budget timeout, then streams every
//             data-memory word out in bank-major order over valid/ready.
//  Ports    : clk      system clock, rising edge
//             rst_n    asynchronous active-low reset
//             en       processor enable, gates cycle counting
//             start    arm pulse, honoured in IDLE and DONE only
//             pc       processor PC bus
//             cycles   enabled cycles of the current / last run
//             done     dump complete, held until re-arm
//             timeout  run ended by MAX_CYCLES rather than HALT_PC
//             bus      memory read port + dump stream (master side)
//  Revision : 1.0 - initial release
// ============================================================================
module mmips_run_monitor #(
   parameter logic [31:0]      HALT_PC    = 32'h44,
   parameter int               N_BANKS    = 64,
   parameter int               BANK_DEPTH = 512,
   parameter int               DATA_W     = 32,
   parameter int               CYC_W      = 32,
   parameter logic [CYC_W-1:0] MAX_CYCLES = '0
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   input  wire logic              en,
   input  wire logic              start,
   input  wire logic [31:0]       pc,
   output      logic [CYC_W-1:0]  cycles,
   output      logic              done,
   output      logic              timeout,
   mmips_run_monitor_if.master    bus
);
   localparam int BANK_W = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
   localparam int ADDR_W = $clog2(BANK_DEPTH);
   localparam int TOTAL  = N_BANKS * BANK_DEPTH;
   localparam int IDX_W  = $clog2(TOTAL);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RUN  = 3'd1,
      S_READ = 3'd2,
      S_CAPT = 3'd3,
      S_SEND = 3'd4,
      S_DONE = 3'd5
   } state_t;

   state_t            r_state;
   logic [CYC_W-1:0]  r_cycles;
   logic [IDX_W-1:0]  r_idx;
   logic              r_done;
   logic              r_timeout;
   logic              r_dump_valid;
   logic              r_dump_last;
   logic [DATA_W-1:0] r_dump_data;

   logic [CYC_W-1:0]  w_cyc_inc;
   logic              w_rd_fire;
   logic [IDX_W-1:0]  w_rd_idx;

   // Saturating increment: the counter sticks at all-ones instead of wrapping.
   assign w_cyc_inc = (&r_cycles) ? r_cycles : r_cycles + CYC_W'(1);

   // Next word is fetched on the accepting handshake so its data lands in the
   // following CAPT cycle; nothing is fetched after the last word.
   assign w_rd_fire = (r_state == S_SEND) && r_dump_valid && bus.dump_ready && !r_dump_last;
   assign w_rd_idx  = w_rd_fire ? r_idx + IDX_W'(1) : r_idx;

   assign bus.mem_rd_en   = (r_state == S_READ) || w_rd_fire;
   assign bus.mem_rd_bank = BANK_W'(32'(w_rd_idx) / BANK_DEPTH);
   assign bus.mem_rd_addr = ADDR_W'(32'(w_rd_idx) % BANK_DEPTH);

   assign bus.dump_valid = r_dump_valid;
   assign bus.dump_data  = r_dump_data;
   assign bus.dump_last  = r_dump_last;
   assign cycles         = r_cycles;
   assign done           = r_done;
   assign timeout        = r_timeout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_cycles     <= '0;
         r_idx        <= '0;
         r_done       <= 1'b0;
         r_timeout    <= 1'b0;
         r_dump_valid <= 1'b0;
         r_dump_last  <= 1'b0;
         r_dump_data  <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_state     <= S_RUN;
                  r_cycles    <= '0;
                  r_idx       <= '0;
                  r_done      <= 1'b0;
                  r_timeout   <= 1'b0;
                  r_dump_last <= 1'b0;
               end
            end
            S_RUN: begin
               if (en) begin
                  r_cycles <= w_cyc_inc;
                  // Halt has priority over a timeout landing on the same edge.
                  if (pc == HALT_PC) begin
                     r_state <= S_READ;
                  end else if ((MAX_CYCLES != '0) && (w_cyc_inc == MAX_CYCLES)) begin
                     r_state   <= S_READ;
                     r_timeout <= 1'b1;
                  end
               end
            end
            S_READ: begin
               r_state <= S_CAPT;
            end
            S_CAPT: begin
               r_dump_data  <= bus.mem_rd_data;
               r_dump_valid <= 1'b1;
               r_dump_last  <= (r_idx == LAST_IDX);
               r_state      <= S_SEND;
            end
            S_SEND: begin
               if (bus.dump_ready) begin
                  // Valid drops for the CAPT cycle so a word is never offered twice.
                  r_dump_valid <= 1'b0;
                  if (r_dump_last) begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_idx   <= r_idx + IDX_W'(1);
                     r_state <= S_CAPT;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_mmips_run_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mmips_run_monitor
//  Purpose  : Self-checking bench for mmips_run_monitor (2 banks x 4 words,
//             MAX_CYCLES=20). Expected dump words are queued when a run ends
//             and compared as the sink accepts them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mmips_run_monitor;
   localparam int          N_BANKS    = 2;
   localparam int          BANK_DEPTH = 4;
   localparam int          DATA_W     = 32;
   localparam int          CYC_W      = 32;
   localparam int          TOTAL      = N_BANKS * BANK_DEPTH;
   localparam logic [31:0] HALT       = 32'h44;

   logic             clk;
   logic             rst_n;
   logic             en;
   logic             start;
   logic [31:0]      pc;
   logic [CYC_W-1:0] cycles;
   logic             done;
   logic             timeout;

   mmips_run_monitor_if #(.N_BANKS(N_BANKS), .BANK_DEPTH(BANK_DEPTH), .DATA_W(DATA_W)) bus ();

   mmips_run_monitor #(
      .HALT_PC    (HALT),
      .N_BANKS    (N_BANKS),
      .BANK_DEPTH (BANK_DEPTH),
      .DATA_W     (DATA_W),
      .CYC_W      (CYC_W),
      .MAX_CYCLES (32'd20)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .start   (start),
      .pc      (pc),
      .cycles  (cycles),
      .done    (done),
      .timeout (timeout),
      .bus     (bus)
   );

   int                n_checks = 0;
   int                n_fail   = 0;
   int                rx_cnt   = 0;
   bit                ready_mode = 0;
   logic [DATA_W-1:0] mem [0:TOTAL-1];
   logic [DATA_W:0]   exp_q [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Memory model: request seen during a cycle, data presented for the next
   // cycle only; random junk otherwise so a mistimed capture is visible.
   initial begin
      bit rd_pend;
      int rd_idx;
      rd_pend = 0;
      rd_idx  = 0;
      bus.mem_rd_data = '0;
      forever begin
         @(negedge clk);
         rd_pend = bus.mem_rd_en;
         rd_idx  = int'(bus.mem_rd_bank) * BANK_DEPTH + int'(bus.mem_rd_addr);
         @(posedge clk);
         #1;
         if (rd_pend && rd_idx < TOTAL) bus.mem_rd_data = mem[rd_idx];
         else                           bus.mem_rd_data = $urandom;
      end
   end

   // Sink ready: always high, or pseudo-random backpressure.
   initial begin
      bus.dump_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.dump_ready = ready_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
   end

   // Sink monitor / scoreboard consumer.
   initial begin
      logic [DATA_W:0] e;
      logic [DATA_W:0] held;
      bit              stalled;
      stalled = 0;
      held    = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stalled = 0;
         end else begin
            if (stalled) begin
               check("stall_valid", bus.dump_valid, 1);
               check("stall_word", {bus.dump_last, bus.dump_data}, held);
            end
            if (bus.dump_valid && !bus.dump_ready) begin
               check("rd_during_stall", bus.mem_rd_en, 0);
               held    = {bus.dump_last, bus.dump_data};
               stalled = 1;
            end else begin
               stalled = 0;
            end
            if (bus.dump_valid && bus.dump_ready) begin
               check("word_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("dump_data", bus.dump_data, e[DATA_W-1:0]);
                  check("dump_last", bus.dump_last, e[DATA_W]);
               end
               rx_cnt++;
            end
         end
      end
   end

   task automatic set_mem(input logic [DATA_W-1:0] base);
      for (int k = 0; k < TOTAL; k++) mem[k] = base + DATA_W'(k);
   endtask

   task automatic check_reset_vals();
      check("rst_cycles", cycles, 0);
      check("rst_done", done, 0);
      check("rst_timeout", timeout, 0);
      check("rst_valid", bus.dump_valid, 0);
      check("rst_last", bus.dump_last, 0);
      check("rst_data", bus.dump_data, 0);
      check("rst_rd_en", bus.mem_rd_en, 0);
      check("rst_bank", bus.mem_rd_bank, 0);
      check("rst_addr", bus.mem_rd_addr, 0);
   endtask

   task automatic arm();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("arm_done_clr", done, 0);
      check("arm_timeout_clr", timeout, 0);
      check("arm_cycles_clr", cycles, 0);
   endtask

   // Drive n enabled RUN edges; with gaps, en is low on every third cycle
   // (pc parked on HALT to prove disabled edges ignore it). Queues the dump.
   task automatic run(input int n, input bit gaps, input bit halt);
      int got = 0;
      int i   = 0;
      while (got < n) begin
         en = !(gaps && (i % 3 == 1));
         if (!en)                        pc = HALT;
         else if (halt && got == n - 1)  pc = HALT;
         else                            pc = 32'h1000 + 32'(i * 4);
         @(posedge clk);
         #1;
         if (en) got++;
         i++;
      end
      en = 1'b0;
      pc = '0;
      for (int k = 0; k < TOTAL; k++) exp_q.push_back({(k == TOTAL - 1), mem[k]});
   endtask

   // Wait for done after the end-of-run edge; optionally pulse start while in SEND.
   task automatic drain(input int exp_lat, input bit exp_to, input bit poke, input int exp_cyc);
      int first = -1;
      int lat   = -1;
      for (int k = 1; k <= 400; k++) begin
         start = (poke && k == 7);
         @(posedge clk);
         #1;
         if (bus.dump_valid && first < 0) first = k;
         if (done) begin
            lat = k;
            break;
         end
      end
      start = 1'b0;
      check("done_reached", lat > 0, 1);
      check("first_valid_lat", first, 2);
      if (exp_lat > 0) check("done_lat", lat, exp_lat);
      check("queue_drained", exp_q.size(), 0);
      check("timeout_flag", timeout, exp_to);
      check("cycles_final", cycles, exp_cyc);
      check("valid_after_done", bus.dump_valid, 0);
      repeat (3) @(posedge clk);
      #1;
      check("done_held", done, 1);
      check("cycles_held", cycles, exp_cyc);
   endtask

   initial begin
      int rx_base;
      bit hit;
      rst_n = 1'b0;
      start = 1'b0;
      en    = 1'b0;
      pc    = '0;
      set_mem(32'h100);

      // Reset held with random inputs.
      for (int k = 0; k < 3; k++) begin
         en    = 1'($urandom);
         start = 1'($urandom);
         pc    = $urandom;
         @(posedge clk);
         #1;
      end
      check_reset_vals();

      // Released without start: HALT_PC on the bus must be ignored.
      start = 1'b0;
      en    = 1'b1;
      pc    = HALT;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("idle_cycles", cycles, 0);
      check("idle_done", done, 0);
      check("idle_valid", bus.dump_valid, 0);
      check("idle_rd_en", bus.mem_rd_en, 0);
      en = 1'b0;
      pc = '0;

      // Basic halt on the 10th enabled edge.
      arm();
      run(10, 0, 1);
      check("basic_cycles", cycles, 10);
      check("basic_timeout", timeout, 0);
      drain(17, 0, 0, 10);

      // Enable gating plus random backpressure.
      set_mem(32'h200);
      ready_mode = 1;
      arm();
      run(10, 1, 1);
      check("gated_cycles", cycles, 10);
      drain(-1, 0, 0, 10);
      ready_mode = 0;

      // Timeout at MAX_CYCLES with no halt.
      set_mem(32'h300);
      arm();
      run(20, 0, 0);
      check("to_cycles", cycles, 20);
      check("to_flag", timeout, 1);
      drain(17, 1, 0, 20);

      // Halt on the timeout edge wins; start pulsed during SEND is ignored.
      set_mem(32'h400);
      arm();
      run(20, 0, 1);
      check("halt20_cycles", cycles, 20);
      check("halt20_timeout", timeout, 0);
      drain(17, 0, 1, 20);

      // Reset in the middle of the dump.
      set_mem(32'h500);
      arm();
      run(7, 0, 1);
      rx_base = rx_cnt;
      hit     = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (rx_cnt >= rx_base + 4) begin
            hit = 1;
            break;
         end
      end
      check("reach_word3", hit, 1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals();
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Fresh run after the abort starts from word 0 with its own count.
      set_mem(32'h600);
      arm();
      run(5, 0, 1);
      check("rerun_cycles", cycles, 5);
      drain(17, 0, 0, 5);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
